// File: rtl/output_pulse_driver_if.sv
// Command channel into output_pulse_driver: a timestamped command strobe plus
// the queue-full back-pressure flag.
interface output_pulse_driver_if;
  logic        valid;
  logic [63:0] cmd_in;
  logic [63:0] timestamp;
  logic        full;

  modport master (output valid, output cmd_in, output timestamp, input full);
  modport slave  (input valid, input cmd_in, input timestamp, output full);
endinterface

// File: rtl/output_pulse_driver.sv
// output_pulse_driver: queues timestamped level/pulse commands and turns each
// one into an 8-bit word per clk for a downstream 8:1 serializer. Bit 0 is the
// earliest slot of a cycle and bit 7 the latest.
//
// Optional build macro LATE_DROP_EN: when defined, a command whose time has
// already passed is discarded instead of being applied at bit 0.
//
// The command being executed stays at the queue head until it completes, so
// "full" counts the executing command as well.
//
// state  | meaning
// IDLE   | queue empty, output held
// WAIT   | head command waiting for its start time
// HIGH   | pulse is high, waiting for its end time
module output_pulse_driver #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [63:0]           counter,
  output_pulse_driver_if.slave  cmd_bus,
  output logic [7:0]            oserdes_data,
  output logic                  curr_level,
  output logic                  late_error,
  output logic                  overflow,
  output logic [1:0]            curr_state
);

  localparam int FIFO_DEPTH_WIDTH = $clog2(FIFO_DEPTH);
  localparam logic [FIFO_DEPTH_WIDTH:0]   CNT_FULL = (FIFO_DEPTH_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [FIFO_DEPTH_WIDTH:0]   CNT_ONE  = (FIFO_DEPTH_WIDTH+1)'(1);
  localparam logic [FIFO_DEPTH_WIDTH-1:0] PTR_ONE  = FIFO_DEPTH_WIDTH'(1);

`ifdef LATE_DROP_EN
  localparam bit LateDrop = 1'b1;
`else
  localparam bit LateDrop = 1'b0;
`endif

  localparam logic [3:0] M_SET_HIGH = 4'd1;
  localparam logic [3:0] M_SET_LOW  = 4'd2;
  localparam logic [3:0] M_PULSE    = 4'd3;
  localparam logic [3:0] M_TOGGLE   = 4'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HIGH = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic [7:0] data_q, data_d;
  logic       late_q, ovf_q;
  logic [FIFO_DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_WIDTH:0]   count_q, count_d;

  logic [3:0]  mode_mem  [FIFO_DEPTH];
  logic [31:0] width_mem [FIFO_DEPTH];
  logic [63:0] ts_mem    [FIFO_DEPTH];

  logic        full_w, empty_w, push, pop, drop, late_set, done;
  logic        level, h_active, t_late, e_late;
  logic [3:0]  h_mode;
  logic [31:0] h_width;
  logic [63:0] h_ts, e_time, t_coarse, e_coarse;
  logic [2:0]  k_at, j_at;
  state_e      next_st;
  logic        unused_cfg;

  // Only config_data[31:0] (pulse width) is meaningful for the current modes.
  assign unused_cfg = ^cmd_bus.cmd_in[63:36];

  function automatic logic [7:0] edge_word(input logic [2:0] k, input logic old_lvl,
                                           input logic new_lvl);
    logic [7:0] m;
    m = 8'hFF << k;
    return ({8{new_lvl}} & m) | ({8{old_lvl}} & ~m);
  endfunction

  assign full_w  = (count_q == CNT_FULL);
  assign empty_w = (count_q == '0);
  assign level   = data_q[7];

  assign h_mode   = mode_mem[rd_ptr_q];
  assign h_width  = width_mem[rd_ptr_q];
  assign h_ts     = ts_mem[rd_ptr_q];
  assign h_active = (h_mode == M_SET_HIGH) || (h_mode == M_SET_LOW) ||
                    (h_mode == M_PULSE)    || (h_mode == M_TOGGLE);

  // End time is a wrapping 64-bit add in fine (1/8 cycle) units.
  assign e_time   = h_ts + {32'd0, h_width};
  assign t_coarse = {3'b000, h_ts[63:3]};
  assign e_coarse = {3'b000, e_time[63:3]};
  assign t_late   = (counter != t_coarse);
  assign e_late   = (counter != e_coarse);
  assign k_at     = t_late ? 3'd0 : h_ts[2:0];
  assign j_at     = e_late ? 3'd0 : e_time[2:0];

  // After completing the head, go straight to the next one if it is queued.
  assign next_st  = (count_q > CNT_ONE) ? S_WAIT : S_IDLE;

  // A push may coincide with a pop even when full: the head slot frees up.
  assign push = cmd_bus.valid && (!full_w || pop);
  assign drop = cmd_bus.valid && !push;

  // Next-state, output word and queue pop decision.
  always_comb begin
    state_d  = state_q;
    data_d   = {8{level}};
    late_set = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty_w) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!h_active) begin
          done = 1'b1;
        end else if (counter >= t_coarse) begin
          late_set = t_late;
          if (t_late && LateDrop) begin
            done = 1'b1;
          end else begin
            unique case (h_mode)
              M_SET_HIGH: begin
                data_d = edge_word(k_at, level, 1'b1);
                done   = 1'b1;
              end
              M_SET_LOW: begin
                data_d = edge_word(k_at, level, 1'b0);
                done   = 1'b1;
              end
              M_TOGGLE: begin
                data_d = edge_word(k_at, level, ~level);
                done   = 1'b1;
              end
              default: begin
                if (h_width == 32'd0) begin
                  done = 1'b1;
                end else if (!t_late && (e_coarse == t_coarse)) begin
                  // rise and fall inside the same word: ones on [k, j-1]
                  data_d = ({8{level}} & ~(8'hFF << k_at)) |
                           ((8'hFF << k_at) & ~(8'hFF << e_time[2:0]));
                  done   = 1'b1;
                end else begin
                  data_d  = edge_word(k_at, level, 1'b1);
                  state_d = S_HIGH;
                end
              end
            endcase
          end
        end
      end
      S_HIGH: begin
        if (counter >= e_coarse) begin
          late_set = e_late;
          data_d   = edge_word(j_at, 1'b1, 1'b0);
          done     = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (done) state_d = next_st;
  end

  assign pop = done;

  // Queue pointer and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + CNT_ONE;
    else if (!push && pop) count_d = count_q - CNT_ONE;
  end

  // Queue storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mode_mem[wr_ptr_q]  <= cmd_bus.cmd_in[3:0];
      width_mem[wr_ptr_q] <= cmd_bus.cmd_in[35:4];
      ts_mem[wr_ptr_q]    <= cmd_bus.timestamp;
    end
  end

  // State, output word, sticky flags and queue pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      data_q   <= 8'h00;
      late_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      late_q   <= late_q | late_set;
      ovf_q    <= ovf_q | drop;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign cmd_bus.full = full_w;
  assign oserdes_data = data_q;
  assign curr_level   = data_q[7];
  assign late_error   = late_q;
  assign overflow     = ovf_q;
  assign curr_state   = state_q;

endmodule

// File: tb/tb_output_pulse_driver.sv
// Bench for output_pulse_driver. Expected values are queued with the counter
// cycle they belong to; a monitor compares them once that cycle's word is out.
module tb_output_pulse_driver;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] cnt   = 64'd0;
  logic [7:0]  oserdes_data;
  logic        curr_level, late_error, overflow;
  logic [1:0]  curr_state;

  output_pulse_driver_if bus();

  output_pulse_driver #(.FIFO_DEPTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .counter      (cnt),
    .cmd_bus      (bus),
    .oserdes_data (oserdes_data),
    .curr_level   (curr_level),
    .late_error   (late_error),
    .overflow     (overflow),
    .curr_state   (curr_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 64'd1;

`ifdef LATE_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  localparam int K_WORD = 0, K_STATE = 1, K_FULL = 2, K_LATE = 3, K_OVF = 4, K_LEVEL = 5;

  typedef struct {
    longint unsigned at;
    int              kind;
    logic [7:0]      val;
  } exp_t;

  exp_t sb[$];
  exp_t keep[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic string kname(input int k);
    case (k)
      K_WORD:  return "oserdes_data";
      K_STATE: return "curr_state";
      K_FULL:  return "full";
      K_LATE:  return "late_error";
      K_OVF:   return "overflow";
      default: return "curr_level";
    endcase
  endfunction

  function automatic logic [7:0] actual(input int k);
    case (k)
      K_WORD:  return oserdes_data;
      K_STATE: return {6'd0, curr_state};
      K_FULL:  return {7'd0, bus.full};
      K_LATE:  return {7'd0, late_error};
      K_OVF:   return {7'd0, overflow};
      default: return {7'd0, curr_level};
    endcase
  endfunction

  task automatic exp_at(input longint unsigned at, input int kind, input logic [7:0] val);
    exp_t e;
    e.at = at; e.kind = kind; e.val = val;
    sb.push_back(e);
  endtask

  // At a falling edge with cnt == N the DUT shows the result for counter N-1.
  initial begin : monitor
    logic [7:0] act;
    forever begin
      @(negedge clk);
      keep = {};
      foreach (sb[i]) begin
        if (sb[i].at == cnt - 64'd1) begin
          n_chk++;
          act = actual(sb[i].kind);
          if (act !== sb[i].val) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h, expected %h",
                     kname(sb[i].kind), sb[i].at, act, sb[i].val);
          end
        end else if (sb[i].at < cnt - 64'd1) begin
          n_chk++;
          n_fail++;
          $display("FAIL %s @cycle %0d: expectation never reached", kname(sb[i].kind), sb[i].at);
        end else begin
          keep.push_back(sb[i]);
        end
      end
      sb = keep;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic goto(input longint unsigned c);
    while (cnt < c) @(negedge clk);
  endtask

  task automatic send(input longint unsigned c, input logic [3:0] mode,
                      input logic [31:0] width, input logic [63:0] coarse,
                      input logic [2:0] sub);
    goto(c);
    bus.valid     = 1'b1;
    bus.cmd_in    = {28'd0, width, mode};
    bus.timestamp = {coarse[60:0], sub};
    @(negedge clk);
    bus.valid     = 1'b0;
  endtask

  initial begin
    bus.valid     = 1'b0;
    bus.cmd_in    = 64'd0;
    bus.timestamp = 64'd0;

    // reset state
    exp_at(3, K_WORD, 8'h00);  exp_at(3, K_STATE, 8'd0); exp_at(3, K_FULL, 8'd0);
    exp_at(3, K_LATE, 8'd0);   exp_at(3, K_OVF, 8'd0);
    goto(4);
    reset = 1'b0;

    // SET_HIGH at {20,3}
    exp_at(11, K_STATE, 8'd1); exp_at(19, K_WORD, 8'h00); exp_at(20, K_WORD, 8'hF8);
    exp_at(20, K_STATE, 8'd0); exp_at(21, K_WORD, 8'hFF); exp_at(21, K_LATE, 8'd0);
    exp_at(21, K_LEVEL, 8'd1);
    send(10, 4'd1, 32'd0, 64'd20, 3'd3);

    // late SET_LOW at {25,4} issued at 30
    exp_at(31, K_WORD, 8'hFF); exp_at(31, K_LATE, 8'd0);
    exp_at(32, K_WORD, DROP ? 8'hFF : 8'h00);
    exp_at(32, K_LATE, 8'd1);  exp_at(32, K_STATE, 8'd0);
    send(30, 4'd2, 32'd0, 64'd25, 3'd4);

    // on-time SET_LOW at {50,0}
    exp_at(49, K_WORD, DROP ? 8'hFF : 8'h00); exp_at(50, K_WORD, 8'h00);
    send(40, 4'd2, 32'd0, 64'd50, 3'd0);

    // PULSE {70,2} width 3: one word
    exp_at(69, K_WORD, 8'h00); exp_at(70, K_WORD, 8'h1C); exp_at(70, K_STATE, 8'd0);
    exp_at(71, K_WORD, 8'h00);
    send(60, 4'd3, 32'd3, 64'd70, 3'd2);

    // PULSE {90,6} width 12: three words
    exp_at(89, K_WORD, 8'h00); exp_at(90, K_WORD, 8'hC0); exp_at(90, K_STATE, 8'd2);
    exp_at(91, K_WORD, 8'hFF); exp_at(91, K_LEVEL, 8'd1); exp_at(92, K_WORD, 8'h03);
    exp_at(92, K_STATE, 8'd0); exp_at(93, K_WORD, 8'h00);
    send(80, 4'd3, 32'd12, 64'd90, 3'd6);

    // PULSE width 0: no edge
    exp_at(109, K_STATE, 8'd1); exp_at(110, K_WORD, 8'h00); exp_at(110, K_STATE, 8'd0);
    exp_at(111, K_WORD, 8'h00);
    send(100, 4'd3, 32'd0, 64'd110, 3'd4);

    // TOGGLE twice
    exp_at(129, K_WORD, 8'h00); exp_at(130, K_WORD, 8'hE0); exp_at(131, K_WORD, 8'hFF);
    send(120, 4'd4, 32'd0, 64'd130, 3'd5);
    exp_at(150, K_WORD, 8'h01); exp_at(151, K_WORD, 8'h00);
    send(140, 4'd4, 32'd0, 64'd150, 3'd1);

    // reserved mode 9 behaves as NOP
    exp_at(161, K_STATE, 8'd1); exp_at(162, K_STATE, 8'd0); exp_at(165, K_WORD, 8'h00);
    send(160, 4'd9, 32'd0, 64'd165, 3'd0);

    // two queued commands in consecutive cycles
    exp_at(180, K_WORD, 8'hFF); exp_at(180, K_STATE, 8'd1); exp_at(181, K_WORD, 8'h7F);
    exp_at(181, K_STATE, 8'd0); exp_at(182, K_WORD, 8'h00);
    send(170, 4'd1, 32'd0, 64'd180, 3'd0);
    send(171, 4'd2, 32'd0, 64'd181, 3'd7);

    // 17 back-to-back valids: 17th dropped, first 16 execute in order
    exp_at(214, K_FULL, 8'd0); exp_at(215, K_FULL, 8'd1); exp_at(215, K_OVF, 8'd0);
    exp_at(216, K_OVF, 8'd1);  exp_at(216, K_FULL, 8'd1);
    for (int i = 0; i < 16; i++) begin
      exp_at(300 + i, K_WORD, (i % 2 == 0) ? 8'hF8 : 8'h07);
      if (i == 0) exp_at(300, K_FULL, 8'd0);
    end
    exp_at(316, K_WORD, 8'h00); exp_at(317, K_WORD, 8'h00);
    goto(200);
    for (int i = 0; i < 17; i++) begin
      bus.valid = 1'b1;
      if (i < 16) begin
        bus.cmd_in    = {60'd0, (i % 2 == 0) ? 4'd1 : 4'd2};
        bus.timestamp = {61'(300 + i), 3'd3};
      end else begin
        bus.cmd_in    = {60'd0, 4'd4};
        bus.timestamp = {61'd316, 3'd0};
      end
      @(negedge clk);
    end
    bus.valid = 1'b0;

    // reset while a long pulse is high
    exp_at(340, K_WORD, 8'hFF); exp_at(340, K_STATE, 8'd2); exp_at(344, K_WORD, 8'hFF);
    exp_at(344, K_STATE, 8'd2); exp_at(344, K_LATE, 8'd1); exp_at(344, K_OVF, 8'd1);
    exp_at(344, K_FULL, 8'd0);
    exp_at(345, K_WORD, 8'h00); exp_at(345, K_STATE, 8'd0); exp_at(345, K_FULL, 8'd0);
    exp_at(345, K_LATE, 8'd0);  exp_at(345, K_OVF, 8'd0);   exp_at(345, K_LEVEL, 8'd0);
    exp_at(346, K_STATE, 8'd0); exp_at(350, K_WORD, 8'h00); exp_at(351, K_WORD, 8'h00);
    exp_at(351, K_STATE, 8'd0);
    send(330, 4'd3, 32'd800, 64'd340, 3'd0);
    send(341, 4'd1, 32'd0, 64'd350, 3'd0);
    goto(345);
    reset = 1'b1;
    goto(346);
    reset = 1'b0;

    goto(360);
    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
